cgia_bus_arbiter: RTL and testbench
===================================

Name: cgia_bus_arbiter

Overview:
- Shares the single CGIA memory port between two non-pipelined Wishbone masters:
  - the video fetcher (V), which is real-time and high priority;
  - the CPU-side register/bitmap master (C), which is low priority.
- V is never preempted.
- C may be parked at a transfer boundary (the cycle its ACK arrives) whenever V requests.
- Sits between the fetcher/CPU bridge and the memory slave; all output muxing is selected by a registered grant.

Parameters:
- AW, 23, address width in 16-bit words.
- DW, 16, data width.
- SW, 2, byte-select width (DW/8).

Ports:
- clk_i  in  1  Wishbone SYSCON clock.
- reset_ni  in  1  asynchronous reset, active-low.
- v_cyc_i, v_stb_i, v_we_i  in  1 each  fetcher bus cycle, strobe, write enable.
- v_adr_i  in  AW  fetcher address.
- v_dat_i  in  DW  fetcher write data.
- v_sel_i  in  SW  fetcher byte selects.
- v_ack_o  out  1  fetcher acknowledge.
- v_dat_o  out  DW  fetcher read data.
- c_cyc_i, c_stb_i, c_we_i, c_adr_i, c_dat_i, c_sel_i, c_ack_o, c_dat_o: same as the v_* set, for the CPU master.
- m_cyc_o, m_stb_o, m_we_o  out  1 each  memory-side cycle, strobe, write enable.
- m_adr_o  out  AW  memory address.
- m_dat_o  out  DW  memory write data.
- m_sel_o  out  SW  memory byte selects.
- m_ack_i  in  1  memory acknowledge.
- m_dat_i  in  DW  memory read data.
- preempt_o  out  8  saturating count of CPU preemptions.
- preempt_clr_i  in  1  synchronous clear of preempt_o.

Behaviour:
- States:
  - IDLE: no grant.
  - VID: V granted.
  - CPU: C granted.
  - TURN: one dead cycle between grants.
- Reset (reset_ni low, asynchronous):
  - state=IDLE, preempt_o=0.
  - m_cyc_o, m_stb_o, v_ack_o, c_ack_o all 0 while in reset and on the first cycle after release.
- Output muxing:
  - In VID: m_* = v_*, gated by v_cyc_i (m_stb_o = v_cyc_i & v_stb_i).
  - In CPU: same, from the c_* inputs.
  - In IDLE and TURN: m_cyc_o = m_stb_o = 0; m_adr_o/m_dat_o/m_sel_o/m_we_o = 0.
- Ack and data routing:
  - v_ack_o = m_ack_i & (state==VID) & v_stb_i; c_ack_o likewise for CPU.
  - v_dat_o and c_dat_o both = m_dat_i; consumers qualify with their own ack.
- Transitions, evaluated every rising edge:
  - IDLE: v_cyc_i -> VID; else c_cyc_i -> CPU; else stay. Simultaneous requests: V wins.
  - VID: v_cyc_i low -> TURN; else stay. No ack-boundary checks.
  - CPU, c_cyc_i low: -> TURN.
  - CPU, m_ack_i high AND v_cyc_i high: -> TURN, preempt_o increments and saturates at 255.
    - Preemption fires only on the acked cycle, so no transfer is ever split.
    - C's next transfer simply sees no ack until C is regranted.
  - CPU, otherwise: stay.
  - TURN: always -> IDLE. Minimum 1 dead cycle between different-master or same-master grants.
- Latency:
  - Request in IDLE -> m_cyc_o asserted on the next cycle (1 clock).
  - Worst-case V wait while C is mid-transfer: C's current transfer to its ack, +1 TURN, +1 IDLE.
- Counter: preempt_clr_i has priority over a same-cycle increment (result 0).
- Stray acks: m_ack_i in IDLE or TURN is ignored (no ack routed, no state effect).
- STB without CYC from either master is ignored.
- Reset asserted mid-transfer: outputs drop immediately (async); the in-flight transfer is abandoned.

Test Plan:
- Reset: hold reset_ni=0 two clocks with v_cyc_i=c_cyc_i=1 -> m_cyc_o=0, both acks 0, preempt_o=0; release -> m_cyc_o=1 one clock later, m_adr_o=v_adr_i.
- Simultaneous request: both cyc/stb high from IDLE with v_adr_i=0x000100, c_adr_i=0x000200 -> m_adr_o=0x000100. V does 4 acked reads of 0x1234 and drops cyc -> after 1 TURN + 1 IDLE, m_adr_o=0x000200.
- Preemption: C holds cyc for 3 writes; V raises cyc during C's 1st transfer -> C's 1st ack delivered, preempt_o=1. Then m_cyc_o=0 for 2 cycles, V served, then C's 2nd write completes with the original c_dat_i.
- No V preemption: V holds cyc 16 transfers while C requests throughout -> c_ack_o never asserted, preempt_o unchanged, m_cyc_o continuous for 16 acks.
- Saturation/clear: force 260 preemptions -> preempt_o=255; pulse preempt_clr_i in the same cycle as a preemption -> preempt_o=0.
- Stray ack / async reset: pulse m_ack_i in IDLE -> no ack out, no state change. Drop reset_ni mid-VID transfer between edges -> m_cyc_o falls without waiting for a clock edge.

Source files
------------

// File: rtl/cgia_bus_arbiter.sv
// Two-master Wishbone arbiter for the CGIA memory port: the video fetcher (V) has
// strict priority and is never preempted; the CPU master (C) yields at an ack boundary.
module cgia_bus_arbiter #(
  parameter int unsigned AW = 23,
  parameter int unsigned DW = 16,
  parameter int unsigned SW = 2
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  // video fetcher
  input  logic          v_cyc_i,
  input  logic          v_stb_i,
  input  logic          v_we_i,
  input  logic [AW-1:0] v_adr_i,
  input  logic [DW-1:0] v_dat_i,
  input  logic [SW-1:0] v_sel_i,
  output logic          v_ack_o,
  output logic [DW-1:0] v_dat_o,
  // CPU-side master
  input  logic          c_cyc_i,
  input  logic          c_stb_i,
  input  logic          c_we_i,
  input  logic [AW-1:0] c_adr_i,
  input  logic [DW-1:0] c_dat_i,
  input  logic [SW-1:0] c_sel_i,
  output logic          c_ack_o,
  output logic [DW-1:0] c_dat_o,
  // memory slave
  output logic          m_cyc_o,
  output logic          m_stb_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_adr_o,
  output logic [DW-1:0] m_dat_o,
  output logic [SW-1:0] m_sel_o,
  input  logic          m_ack_i,
  input  logic [DW-1:0] m_dat_i,
  // preemption statistics
  output logic [7:0]    preempt_o,
  input  logic          preempt_clr_i
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VID  = 2'd1,
    S_CPU  = 2'd2,
    S_TURN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] preempt_q, preempt_d;
  logic          preempt_ev;

  // Grant and preemption counter registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      preempt_q <= '0;
    end else begin
      state_q   <= state_d;
      preempt_q <= preempt_d;
    end
  end

  // Next grant; C only yields on the cycle its transfer is acked
  always_comb begin
    state_d    = state_q;
    preempt_ev = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (v_cyc_i)      state_d = S_VID;
        else if (c_cyc_i) state_d = S_CPU;
      end
      S_VID: begin
        if (!v_cyc_i) state_d = S_TURN;
      end
      S_CPU: begin
        if (!c_cyc_i) begin
          state_d = S_TURN;
        end else if (m_ack_i && v_cyc_i) begin
          state_d    = S_TURN;
          preempt_ev = 1'b1;
        end
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating counter; a clear wins over a same-cycle preemption
  always_comb begin
    preempt_d = preempt_q;
    if (preempt_clr_i) begin
      preempt_d = '0;
    end else if (preempt_ev && (preempt_q != {CW{1'b1}})) begin
      preempt_d = preempt_q + CW'(1);
    end
  end

  // Memory-side mux and ack routing follow the registered grant
  always_comb begin
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_adr_o = '0;
    m_dat_o = '0;
    m_sel_o = '0;
    v_ack_o = 1'b0;
    c_ack_o = 1'b0;
    case (state_q)
      S_VID: begin
        m_cyc_o = v_cyc_i;
        m_stb_o = v_cyc_i & v_stb_i;
        if (v_cyc_i) begin
          m_we_o  = v_we_i;
          m_adr_o = v_adr_i;
          m_dat_o = v_dat_i;
          m_sel_o = v_sel_i;
        end
        v_ack_o = m_ack_i & v_stb_i;
      end
      S_CPU: begin
        m_cyc_o = c_cyc_i;
        m_stb_o = c_cyc_i & c_stb_i;
        if (c_cyc_i) begin
          m_we_o  = c_we_i;
          m_adr_o = c_adr_i;
          m_dat_o = c_dat_i;
          m_sel_o = c_sel_i;
        end
        c_ack_o = m_ack_i & c_stb_i;
      end
      default: ;
    endcase
  end

  assign v_dat_o   = m_dat_i;
  assign c_dat_o   = m_dat_i;
  assign preempt_o = preempt_q;

endmodule

// File: tb/tb_cgia_bus_arbiter.sv
// Bench for cgia_bus_arbiter: directed scenarios plus random traffic, all checked
// against an owner/cooldown reference model of the arbitration rules.
module tb_cgia_bus_arbiter;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 2;

  logic          clk_i, reset_ni;
  logic          v_cyc_i, v_stb_i, v_we_i, v_ack_o;
  logic [AW-1:0] v_adr_i;
  logic [DW-1:0] v_dat_i, v_dat_o;
  logic [SW-1:0] v_sel_i;
  logic          c_cyc_i, c_stb_i, c_we_i, c_ack_o;
  logic [AW-1:0] c_adr_i;
  logic [DW-1:0] c_dat_i, c_dat_o;
  logic [SW-1:0] c_sel_i;
  logic          m_cyc_o, m_stb_o, m_we_o, m_ack_i;
  logic [AW-1:0] m_adr_o;
  logic [DW-1:0] m_dat_o, m_dat_i;
  logic [SW-1:0] m_sel_o;
  logic [7:0]    preempt_o;
  logic          preempt_clr_i;

  cgia_bus_arbiter #(.AW(AW), .DW(DW), .SW(SW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .v_cyc_i(v_cyc_i), .v_stb_i(v_stb_i), .v_we_i(v_we_i), .v_adr_i(v_adr_i),
    .v_dat_i(v_dat_i), .v_sel_i(v_sel_i), .v_ack_o(v_ack_o), .v_dat_o(v_dat_o),
    .c_cyc_i(c_cyc_i), .c_stb_i(c_stb_i), .c_we_i(c_we_i), .c_adr_i(c_adr_i),
    .c_dat_i(c_dat_i), .c_sel_i(c_sel_i), .c_ack_o(c_ack_o), .c_dat_o(c_dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
    .preempt_o(preempt_o), .preempt_clr_i(preempt_clr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          mcyc, mstb, mwe;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          vack, cack;
    logic [DW-1:0] vdat, cdat;
    logic [7:0]    pre;
  } obs_t;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus (0 none, 1 video, 2 cpu), whether the
  // forced dead cycle after a release is still pending, and the preemption tally.
  int owner_m = 0;
  bit cool_m  = 0;
  int pre_m   = 0;

  function automatic obs_t exp_out();
    obs_t e;
    e      = '0;
    e.vdat = m_dat_i;
    e.cdat = m_dat_i;
    e.pre  = 8'(pre_m);
    if (owner_m == 1) begin
      e.mcyc = v_cyc_i;
      e.mstb = v_cyc_i & v_stb_i;
      if (v_cyc_i) begin
        e.mwe = v_we_i; e.adr = v_adr_i; e.dat = v_dat_i; e.sel = v_sel_i;
      end
      e.vack = m_ack_i & v_stb_i;
    end else if (owner_m == 2) begin
      e.mcyc = c_cyc_i;
      e.mstb = c_cyc_i & c_stb_i;
      if (c_cyc_i) begin
        e.mwe = c_we_i; e.adr = c_adr_i; e.dat = c_dat_i; e.sel = c_sel_i;
      end
      e.cack = m_ack_i & c_stb_i;
    end
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = '{m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o,
          v_ack_o, c_ack_o, v_dat_o, c_dat_o, preempt_o};
    return o;
  endfunction

  task automatic model_reset();
    owner_m = 0; cool_m = 0; pre_m = 0;
  endtask

  // Advance the model with the inputs seen at the edge, then step past the edge.
  task automatic tick();
    int n_owner;
    bit n_cool;
    bit ev;
    n_owner = owner_m; n_cool = cool_m; ev = 0;
    if (owner_m == 0) begin
      if (cool_m)       n_cool = 0;
      else if (v_cyc_i) n_owner = 1;
      else if (c_cyc_i) n_owner = 2;
    end else if (owner_m == 1) begin
      if (!v_cyc_i) begin n_owner = 0; n_cool = 1; end
    end else begin
      if (!c_cyc_i) begin
        n_owner = 0; n_cool = 1;
      end else if (m_ack_i && v_cyc_i) begin
        n_owner = 0; n_cool = 1; ev = 1;
      end
    end
    @(posedge clk_i);
    if (!reset_ni) begin
      model_reset();
    end else begin
      owner_m = n_owner;
      cool_m  = n_cool;
      if (preempt_clr_i) pre_m = 0;
      else if (ev && pre_m < 255) pre_m = pre_m + 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    v_cyc_i = 0; v_stb_i = 0; v_we_i = 0; v_adr_i = '0; v_dat_i = '0; v_sel_i = '0;
    c_cyc_i = 0; c_stb_i = 0; c_we_i = 0; c_adr_i = '0; c_dat_i = '0; c_sel_i = '0;
    m_ack_i = 0; m_dat_i = '0; preempt_clr_i = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_ni = 0;
    model_reset();
    tick();
    tick();
    reset_ni = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    v_cyc_i = 1; v_stb_i = 1; c_cyc_i = 1; c_stb_i = 1;
    v_adr_i = 23'h000155; c_adr_i = 23'h000255;
    reset_ni = 0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({m_cyc_o, m_stb_o, v_ack_o, c_ack_o, preempt_o} !== 12'h000) begin
        bad++;
        $display("FAIL reset_hold got cyc=%b stb=%b vack=%b cack=%b pre=%0d exp all 0",
                 m_cyc_o, m_stb_o, v_ack_o, c_ack_o, preempt_o);
      end
    end
    reset_ni = 1;
    #1;
    total++;
    if (m_cyc_o !== 1'b0) begin
      bad++; $display("FAIL reset_release_first got m_cyc=%b exp 0", m_cyc_o);
    end
    tick();
    total++;
    if (m_cyc_o !== 1'b1 || m_adr_o !== 23'h000155) begin
      bad++; $display("FAIL reset_grant got cyc=%b adr=%h exp cyc=1 adr=000155", m_cyc_o, m_adr_o);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    v_cyc_i = 1; v_stb_i = 1; v_adr_i = 23'h000100;
    c_cyc_i = 1; c_stb_i = 1; c_adr_i = 23'h000200;
    #1;
    tick();
    total++;
    if (m_adr_o !== 23'h000100 || m_cyc_o !== 1'b1) begin
      bad++; $display("FAIL simul_v_wins got adr=%h cyc=%b exp adr=000100 cyc=1", m_adr_o, m_cyc_o);
    end
    for (int i = 0; i < 4; i++) begin
      m_ack_i = 1; m_dat_i = 16'h1234;
      #1;
      total++;
      if (v_ack_o !== 1'b1 || v_dat_o !== 16'h1234 || c_ack_o !== 1'b0) begin
        bad++; $display("FAIL simul_vread%0d got vack=%b vdat=%h cack=%b exp 1 1234 0",
                        i, v_ack_o, v_dat_o, c_ack_o);
      end
      tick();
    end
    v_cyc_i = 0; v_stb_i = 0; m_ack_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (m_cyc_o !== 1'b0) begin
        bad++; $display("FAIL simul_gap%0d got m_cyc=%b exp 0", i, m_cyc_o);
      end
      tick();
    end
    total++;
    if (m_adr_o !== 23'h000200 || m_cyc_o !== 1'b1) begin
      bad++; $display("FAIL simul_c_next got adr=%h cyc=%b exp adr=000200 cyc=1", m_adr_o, m_cyc_o);
    end
  endtask

  task automatic test_preempt();
    apply_reset();
    c_cyc_i = 1; c_stb_i = 1; c_we_i = 1; c_adr_i = 23'h000300; c_dat_i = 16'hA5A5;
    v_adr_i = 23'h000400;
    #1;
    tick();
    v_cyc_i = 1; v_stb_i = 1;
    #1;
    total++;
    if (m_adr_o !== 23'h000300 || m_we_o !== 1'b1 || c_ack_o !== 1'b0) begin
      bad++; $display("FAIL preempt_wait got adr=%h we=%b cack=%b exp 000300 1 0", m_adr_o, m_we_o, c_ack_o);
    end
    tick();
    m_ack_i = 1;
    #1;
    total++;
    if (c_ack_o !== 1'b1) begin
      bad++; $display("FAIL preempt_c_ack got cack=%b exp 1", c_ack_o);
    end
    tick();
    m_ack_i = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (m_cyc_o !== 1'b0 || preempt_o !== 8'd1) begin
        bad++; $display("FAIL preempt_gap%0d got cyc=%b pre=%0d exp cyc=0 pre=1", i, m_cyc_o, preempt_o);
      end
      tick();
    end
    m_ack_i = 1;
    #1;
    total++;
    if (m_adr_o !== 23'h000400 || v_ack_o !== 1'b1) begin
      bad++; $display("FAIL preempt_v_served got adr=%h vack=%b exp 000400 1", m_adr_o, v_ack_o);
    end
    tick();
    v_cyc_i = 0; v_stb_i = 0; m_ack_i = 0;
    #1;
    tick(); tick(); tick();
    m_ack_i = 1;
    #1;
    total++;
    if (m_dat_o !== 16'hA5A5 || m_we_o !== 1'b1 || c_ack_o !== 1'b1 || preempt_o !== 8'd1) begin
      bad++; $display("FAIL preempt_c_resume got dat=%h we=%b cack=%b pre=%0d exp A5A5 1 1 1",
                      m_dat_o, m_we_o, c_ack_o, preempt_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_no_v_preempt();
    apply_reset();
    v_cyc_i = 1; v_stb_i = 1; c_cyc_i = 1; c_stb_i = 1;
    #1;
    tick();
    for (int i = 0; i < 16; i++) begin
      m_ack_i = 1; v_adr_i = AW'(i);
      #1;
      total++;
      if (m_cyc_o !== 1'b1 || v_ack_o !== 1'b1 || c_ack_o !== 1'b0 || preempt_o !== 8'd0) begin
        bad++; $display("FAIL no_vpre%0d got cyc=%b vack=%b cack=%b pre=%0d exp 1 1 0 0",
                        i, m_cyc_o, v_ack_o, c_ack_o, preempt_o);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    obs_t e, o;
    apply_reset();
    c_cyc_i = 1; c_stb_i = 1;
    #1;
    tick();
    for (int i = 0; i < 260; i++) begin
      v_cyc_i = 1; m_ack_i = 1;
      #1;
      e = exp_out(); o = observe();
      total++;
      if (o !== e) begin
        bad++; $display("FAIL sat_iter%0d got=%h exp=%h", i, o, e);
      end
      tick();
      v_cyc_i = 0; m_ack_i = 0;
      tick();
      tick();
    end
    total++;
    if (preempt_o !== 8'd255) begin
      bad++; $display("FAIL sat_255 got pre=%0d exp 255", preempt_o);
    end
    v_cyc_i = 1; m_ack_i = 1; preempt_clr_i = 1;
    #1;
    tick();
    preempt_clr_i = 0; v_cyc_i = 0; m_ack_i = 0;
    #1;
    total++;
    if (preempt_o !== 8'd0) begin
      bad++; $display("FAIL sat_clr_wins got pre=%0d exp 0", preempt_o);
    end
    idle_inputs();
  endtask

  task automatic test_stray_async();
    apply_reset();
    m_ack_i = 1;
    #1;
    total++;
    if (v_ack_o !== 1'b0 || c_ack_o !== 1'b0 || m_cyc_o !== 1'b0) begin
      bad++; $display("FAIL stray_ack got vack=%b cack=%b cyc=%b exp 0 0 0", v_ack_o, c_ack_o, m_cyc_o);
    end
    tick();
    m_ack_i = 0; c_cyc_i = 1; c_stb_i = 1; c_adr_i = 23'h000077;
    #1;
    tick();
    total++;
    if (m_cyc_o !== 1'b1 || m_adr_o !== 23'h000077) begin
      bad++; $display("FAIL stray_no_effect got cyc=%b adr=%h exp 1 000077", m_cyc_o, m_adr_o);
    end
    idle_inputs();
    v_cyc_i = 1; v_stb_i = 1;
    tick(); tick(); tick(); tick();
    total++;
    if (m_cyc_o !== 1'b1) begin
      bad++; $display("FAIL async_setup got cyc=%b exp 1", m_cyc_o);
    end
    #2;
    reset_ni = 0;
    model_reset();
    #1;
    total++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0) begin
      bad++; $display("FAIL async_drop got cyc=%b stb=%b exp 0 0", m_cyc_o, m_stb_o);
    end
    tick();
    reset_ni = 1;
    idle_inputs();
  endtask

  task automatic test_random();
    obs_t e, o;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) v_cyc_i = ~v_cyc_i;
      if ($urandom_range(4) == 0) c_cyc_i = ~c_cyc_i;
      v_stb_i = ($urandom_range(3) != 0);
      c_stb_i = ($urandom_range(3) != 0);
      v_we_i  = 1'($urandom); c_we_i = 1'($urandom);
      v_adr_i = AW'($urandom); c_adr_i = AW'($urandom);
      v_dat_i = DW'($urandom); c_dat_i = DW'($urandom);
      v_sel_i = SW'($urandom); c_sel_i = SW'($urandom);
      m_ack_i = 1'($urandom); m_dat_i = DW'($urandom);
      preempt_clr_i = ($urandom_range(40) == 0);
      #1;
      e = exp_out(); o = observe();
      total++;
      if (o !== e) begin
        bad++; $display("FAIL random_cyc%0d got=%h exp=%h", i, o, e);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_ni = 0;
    test_reset();
    test_simultaneous();
    test_preempt();
    test_no_v_preempt();
    test_saturation();
    test_stray_async();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
